// File: rtl/clock_gating_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cg_ctrl_pkg
// Purpose  : Shared per-domain state encoding and Moore output decode for the
//            automatic clock-gating controller.
// Revision : 1.0 - initial release
// ============================================================================
package cg_ctrl_pkg;

  typedef enum logic [2:0] {
    CG_RUN   = 3'd0,
    CG_IDLE  = 3'd1,
    CG_DRAIN = 3'd2,
    CG_OFF   = 3'd3,
    CG_WAKE  = 3'd4
  } cg_state_e;

  typedef struct packed {
    logic clk_en;
    logic gate_req;
    logic dom_ready;
    logic gated_status;
  } cg_outs_t;

  function automatic cg_outs_t st_to_outs(input cg_state_e st);
    cg_outs_t o;
    case (st)
      CG_RUN:   o = '{clk_en: 1'b1, gate_req: 1'b0, dom_ready: 1'b1, gated_status: 1'b0};
      CG_IDLE:  o = '{clk_en: 1'b1, gate_req: 1'b0, dom_ready: 1'b1, gated_status: 1'b0};
      CG_DRAIN: o = '{clk_en: 1'b1, gate_req: 1'b1, dom_ready: 1'b1, gated_status: 1'b0};
      CG_OFF:   o = '{clk_en: 1'b0, gate_req: 1'b1, dom_ready: 1'b0, gated_status: 1'b1};
      CG_WAKE:  o = '{clk_en: 1'b1, gate_req: 1'b0, dom_ready: 1'b0, gated_status: 1'b0};
      default:  o = '{clk_en: 1'b1, gate_req: 1'b0, dom_ready: 1'b1, gated_status: 1'b0};
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_gating_ctrl_domain_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cg_domain_fsm
// Purpose  : One gated domain: idle counting, quiesce handshake, OFF and a
//            fixed-length wake-up, with outputs decoded from the state register.
// Revision : 1.0 - initial release
// ============================================================================
module cg_domain_fsm
  import cg_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 4,
  parameter int DRAIN_TO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_auto_en_i,
  input  logic [CNT_W-1:0] cfg_idle_thresh_i,
  input  logic             busy_i,
  input  logic             wake_req_i,
  input  logic             gate_ack_i,
  input  logic             wake_grant_i,
  output logic             wake_cand_o,
  output logic             in_wake_o,
  output logic             clk_en_o,
  output logic             gate_req_o,
  output logic             dom_ready_o,
  output logic             gated_status_o
);

  localparam int DRN_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
  localparam int WAK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [WAK_W-1:0] wake_cnt_q, wake_cnt_d;

  logic             stay;
  logic [CNT_W-1:0] thresh_eff;
  logic [CNT_W:0]   idle_inc;
  cg_outs_t         outs;

  assign stay       = busy_i | wake_req_i | ~cfg_auto_en_i;
  assign thresh_eff = (cfg_idle_thresh_i == '0) ? CNT_W'(1) : cfg_idle_thresh_i;
  // One extra bit keeps the threshold compare exact at the saturation point.
  assign idle_inc   = {1'b0, idle_cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    drain_cnt_d = '0;
    wake_cnt_d  = '0;
    case (state_q)
      CG_RUN: begin
        idle_cnt_d = '0;
        if (!stay) begin
          idle_cnt_d = CNT_W'(1);
          state_d    = (thresh_eff == CNT_W'(1)) ? CG_DRAIN : CG_IDLE;
        end
      end
      CG_IDLE: begin
        if (stay) begin
          state_d    = CG_RUN;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_inc[CNT_W] ? idle_cnt_q : idle_inc[CNT_W-1:0];
          if (idle_inc >= {1'b0, thresh_eff}) state_d = CG_DRAIN;
        end
      end
      CG_DRAIN: begin
        if (stay) begin
          state_d    = CG_RUN;
          idle_cnt_d = '0;
        end else if (gate_ack_i) begin
          state_d = CG_OFF;
        end else if (drain_cnt_q == DRN_W'(DRAIN_TO - 1)) begin
          state_d    = CG_RUN;
          idle_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      CG_OFF: begin
        if (wake_grant_i) state_d = CG_WAKE;
      end
      CG_WAKE: begin
        if (wake_cnt_q == WAK_W'(WAKE_CYC - 1)) begin
          state_d    = CG_RUN;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAK_W'(1);
        end
      end
      default: begin
        state_d    = CG_RUN;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CG_RUN;
      idle_cnt_q  <= '0;
      drain_cnt_q <= '0;
      wake_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
    end
  end

  assign outs           = st_to_outs(state_q);
  assign clk_en_o       = outs.clk_en;
  assign gate_req_o     = outs.gate_req;
  assign dom_ready_o    = outs.dom_ready;
  assign gated_status_o = outs.gated_status;
  assign wake_cand_o    = (state_q == CG_OFF) & stay;
  assign in_wake_o      = (state_q == CG_WAKE);

endmodule
`default_nettype wire

// File: rtl/clock_gating_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_gating_ctrl
// Purpose  : N_DOM-domain automatic clock-gating controller with a round-robin
//            wake arbiter that admits at most one waking domain at a time.
// Revision : 1.0 - initial release
// ============================================================================
module clock_gating_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 4,
  parameter int DRAIN_TO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_auto_en_i,
  input  logic [CNT_W-1:0] cfg_idle_thresh_i,
  input  logic [N_DOM-1:0] busy_i,
  input  logic [N_DOM-1:0] wake_req_i,
  input  logic [N_DOM-1:0] gate_ack_i,
  output logic [N_DOM-1:0] clk_en_o,
  output logic [N_DOM-1:0] gate_req_o,
  output logic [N_DOM-1:0] dom_ready_o,
  output logic [N_DOM-1:0] gated_status_o
);

  localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic [N_DOM-1:0] wake_cand, in_wake, wake_grant;
  logic             any_wake;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;
  int               cand_idx;

  for (genvar d = 0; d < N_DOM; d++) begin : g_dom
    cg_domain_fsm #(
      .CNT_W   (CNT_W),
      .WAKE_CYC(WAKE_CYC),
      .DRAIN_TO(DRAIN_TO)
    ) u_fsm (
      .clk              (clk),
      .rst              (rst),
      .cfg_auto_en_i    (cfg_auto_en_i),
      .cfg_idle_thresh_i(cfg_idle_thresh_i),
      .busy_i           (busy_i[d]),
      .wake_req_i       (wake_req_i[d]),
      .gate_ack_i       (gate_ack_i[d]),
      .wake_grant_i     (wake_grant[d]),
      .wake_cand_o      (wake_cand[d]),
      .in_wake_o        (in_wake[d]),
      .clk_en_o         (clk_en_o[d]),
      .gate_req_o       (gate_req_o[d]),
      .dom_ready_o      (dom_ready_o[d]),
      .gated_status_o   (gated_status_o[d])
    );
  end

  assign any_wake = |in_wake;

  // Scan from the pointer for the first candidate; hold off while anyone wakes.
  always_comb begin
    wake_grant = '0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    cand_idx   = 0;
    for (int k = 0; k < N_DOM; k++) begin
      cand_idx = (int'(rr_ptr_q) + k) % N_DOM;
      if (!grant_vld && wake_cand[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(cand_idx);
      end
    end
    if (any_wake) grant_vld = 1'b0;
    if (grant_vld) wake_grant[grant_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PTR_W'(N_DOM - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_gating_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_gating_ctrl
// Purpose  : Directed self-checking bench for clock_gating_ctrl (4 domains).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_gating_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_auto_en;
  logic [7:0] cfg_idle_thresh;
  logic [3:0] busy, wake_req, gate_ack;
  logic [3:0] clk_en, gate_req, dom_ready, gated_status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_gating_ctrl #(.N_DOM(4), .CNT_W(8), .WAKE_CYC(4), .DRAIN_TO(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_auto_en_i    (cfg_auto_en),
    .cfg_idle_thresh_i(cfg_idle_thresh),
    .busy_i           (busy),
    .wake_req_i       (wake_req),
    .gate_ack_i       (gate_ack),
    .clk_en_o         (clk_en),
    .gate_req_o       (gate_req),
    .dom_ready_o      (dom_ready),
    .gated_status_o   (gated_status)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n edges; sample 1 time unit after each edge. WAKE = clk_en & ~dom_ready.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk_eq("one_wake", {31'b0, ($countones(clk_en & ~dom_ready) > 1)}, 32'd0);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] ce, input logic [3:0] gr,
                          input logic [3:0] dr, input logic [3:0] gs);
    chk_eq({tag, ".clk_en"},    {28'b0, clk_en},       {28'b0, ce});
    chk_eq({tag, ".gate_req"},  {28'b0, gate_req},     {28'b0, gr});
    chk_eq({tag, ".dom_ready"}, {28'b0, dom_ready},    {28'b0, dr});
    chk_eq({tag, ".gated"},     {28'b0, gated_status}, {28'b0, gs});
  endtask

  initial begin
    rst = 1'b1; cfg_auto_en = 1'b1; cfg_idle_thresh = 8'd4;
    busy = 4'b1110; wake_req = 4'b0000; gate_ack = 4'b0000;
    step(2);
    chk_outs("reset", 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    rst = 1'b0;

    // Domain 0 idles: gate_req after the 4th idle edge, ack two edges later
    step(3);
    chk_outs("t1_idle3", 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    step(1);
    chk_outs("t1_drain", 4'b1111, 4'b0001, 4'b1111, 4'b0000);
    step(1);
    chk_outs("t1_wait", 4'b1111, 4'b0001, 4'b1111, 4'b0000);
    gate_ack = 4'b0001;
    step(1);
    chk_outs("t1_off", 4'b1110, 4'b0001, 4'b1110, 4'b0001);
    gate_ack = 4'b0000;

    // Domain 1: busy pulse after 3 idle cycles restarts the count
    busy = 4'b1100;
    step(3);
    busy = 4'b1110;
    step(1);
    chk_eq("t2_back_run", {28'b0, gate_req}, 32'h1);
    busy = 4'b1100;
    step(3);
    chk_eq("t2_fresh3", {28'b0, gate_req}, 32'h1);
    step(1);
    chk_eq("t2_drain", {28'b0, gate_req}, 32'h3);

    // Domain 1: DRAIN times out after 16 cycles without ack
    step(15);
    chk_eq("t3_drain15", {28'b0, gate_req}, 32'h3);
    step(1);
    chk_outs("t3_abort", 4'b1110, 4'b0001, 4'b1110, 4'b0001);
    busy = 4'b1110;
    step(1);
    busy = 4'b1100;
    step(4);
    chk_eq("t3_drain2", {28'b0, gate_req}, 32'h3);
    wake_req = 4'b0010; gate_ack = 4'b0010;
    step(1);
    chk_outs("t3_stay_wins", 4'b1110, 4'b0001, 4'b1110, 4'b0001);
    wake_req = 4'b0000; gate_ack = 4'b0000;

    // RR fairness: wake 1 alone (pointer -> 2), then 0 and 3 together
    busy = 4'b0100;
    step(4);
    chk_eq("t5_drain13", {28'b0, gate_req}, 32'hb);
    gate_ack = 4'b1010;
    step(1);
    chk_outs("t5_off013", 4'b0100, 4'b1011, 4'b0100, 4'b1011);
    gate_ack = 4'b0000; wake_req = 4'b0010;
    step(1);
    chk_outs("t5_wake1", 4'b0110, 4'b1001, 4'b0100, 4'b1001);
    wake_req = 4'b0000; busy = 4'b0110;
    step(3);
    chk_eq("t5_w1_notrdy", {28'b0, dom_ready}, 32'h4);
    step(1);
    chk_eq("t5_w1_rdy", {28'b0, dom_ready}, 32'h6);
    wake_req = 4'b1001;
    step(1);
    chk_outs("t5_grant3", 4'b1110, 4'b0001, 4'b0110, 4'b0001);
    step(4);
    chk_outs("t5_run3", 4'b1110, 4'b0001, 4'b1110, 4'b0001);
    step(1);
    chk_outs("t5_grant0", 4'b1111, 4'b0000, 4'b1110, 4'b0000);
    step(4);
    chk_eq("t5_run0", {28'b0, dom_ready}, 32'hf);

    // Fresh reset, all OFF, simultaneous wake: order 0,1,2,3
    rst = 1'b1; busy = 4'b1111; wake_req = 4'b0000;
    step(1);
    rst = 1'b0; busy = 4'b0000;
    step(4);
    chk_eq("t4_drain_all", {28'b0, gate_req}, 32'hf);
    gate_ack = 4'b1111;
    step(1);
    chk_outs("t4_all_off", 4'b0000, 4'b1111, 4'b0000, 4'b1111);
    gate_ack = 4'b0000; wake_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk_eq("t4_grant_ce", {28'b0, clk_en},    (32'd1 << (k + 1)) - 1);
      chk_eq("t4_grant_dr", {28'b0, dom_ready}, (32'd1 << k) - 1);
      step(3);
      chk_eq("t4_wait_dr",  {28'b0, dom_ready}, (32'd1 << k) - 1);
      step(1);
      chk_eq("t4_ready_dr", {28'b0, dom_ready}, (32'd1 << (k + 1)) - 1);
    end

    // Reset while domain 1 is OFF and domain 2 is in WAKE
    wake_req = 4'b0000;
    step(4);
    gate_ack = 4'b1111;
    step(1);
    gate_ack = 4'b0000; wake_req = 4'b0100;
    step(1);
    wake_req = 4'b0000;
    step(1);
    chk_outs("t6_pre", 4'b0100, 4'b1011, 4'b0000, 4'b1011);
    rst = 1'b1; busy = 4'b1111;
    step(1);
    chk_outs("t6_rst", 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    rst = 1'b0; busy = 4'b0000;

    // cfg_auto_en=0 wakes every OFF domain in sequence
    step(4);
    gate_ack = 4'b1111;
    step(1);
    chk_eq("t6_all_off", {28'b0, gated_status}, 32'hf);
    gate_ack = 4'b0000; cfg_auto_en = 1'b0;
    step(1);
    chk_eq("t6_auto_w0", {28'b0, clk_en}, 32'h1);
    for (int k = 1; k < 4; k++) begin
      step(5);
      chk_eq("t6_auto_wk", {28'b0, clk_en}, (32'd1 << (k + 1)) - 1);
    end
    step(4);
    chk_outs("t6_auto_done", 4'b1111, 4'b0000, 4'b1111, 4'b0000);

    // Threshold 0 behaves as 1: first idle edge goes straight to DRAIN
    cfg_auto_en = 1'b1; cfg_idle_thresh = 8'd0; busy = 4'b1110;
    step(1);
    chk_eq("thresh0", {28'b0, gate_req}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
